// File: rtl/mem_port_arbiter_if.sv
// External memory port shared by fetch and load/store traffic.
// The arbiter is the master; the memory (or bench model) is the slave.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_be,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_be,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, data-first
// with a fetch anti-starvation streak limit, flush discard and a bus watchdog.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned D_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    // Fetch side
    input  logic                      i_req_i,
    input  logic [31:0]               i_addr_i,
    input  logic                      i_flush_i,
    output logic [31:0]               i_rdata_o,
    output logic                      iready_n_o,
    // Load/store side
    input  logic                      d_req_i,
    input  logic                      d_we_i,
    input  logic [3:0]                d_be_i,
    input  logic [31:0]               d_addr_i,
    input  logic [31:0]               d_wdata_i,
    output logic [31:0]               d_rdata_o,
    output logic                      dready_n_o,
    output logic                      dbusy_o,
    // External port
    mem_port_arbiter_if.master        bus,
    output logic                      bus_timeout_o
);

    localparam int unsigned SW      = (D_STREAK_MAX > 0) ? $clog2(D_STREAK_MAX + 1) : 1;
    localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          WdogEn  = (TIMEOUT != 0);
    localparam logic [SW-1:0] StreakMax = SW'(D_STREAK_MAX);
    localparam logic [TW-1:0] TLast     = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIBus,
        StDBus
    } state_e;

    state_e        state_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [3:0]    bus_be_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [31:0]   i_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          iready_n_q;
    logic          dready_n_q;
    logic          st_done_q;
    logic          drop_q;
    logic          bus_timeout_q;
    logic [SW-1:0] streak_q;
    logic [TW-1:0] tcount_q;

    logic          i_live;
    logic          d_live;
    logic          d_grant;
    logic          i_grant;
    logic          tmo_hit;
    logic          done;
    logic [31:0]   rdata;

    // A requester in its completion cycle may still be showing its old request.
    assign i_live  = i_req_i & iready_n_q;
    assign d_live  = d_req_i & dready_n_q & ~st_done_q;
    assign d_grant = d_live & ~(i_live & (streak_q == StreakMax));
    assign i_grant = ~d_grant & i_live & ~i_flush_i;

    assign tmo_hit = WdogEn & ~bus.bus_ack & (tcount_q == TLast);
    assign done    = bus.bus_ack | tmo_hit;
    assign rdata   = bus.bus_ack ? bus.bus_rdata : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_be_q      <= 4'h0;
            bus_addr_q    <= 32'h0;
            bus_wdata_q   <= 32'h0;
            i_rdata_q     <= 32'h0;
            d_rdata_q     <= 32'h0;
            iready_n_q    <= 1'b1;
            dready_n_q    <= 1'b1;
            st_done_q     <= 1'b0;
            drop_q        <= 1'b0;
            bus_timeout_q <= 1'b0;
            streak_q      <= '0;
            tcount_q      <= '0;
        end else begin
            iready_n_q <= 1'b1;
            dready_n_q <= 1'b1;
            st_done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (d_grant) begin
                        state_q     <= StDBus;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= d_we_i;
                        bus_be_q    <= d_we_i ? d_be_i : 4'hF;
                        bus_addr_q  <= d_addr_i;
                        bus_wdata_q <= d_wdata_i;
                        tcount_q    <= '0;
                        if (!i_live) begin
                            streak_q <= '0;
                        end else if (streak_q != StreakMax) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end else if (i_grant) begin
                        state_q     <= StIBus;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_be_q    <= 4'hF;
                        bus_addr_q  <= i_addr_i;
                        bus_wdata_q <= 32'h0;
                        tcount_q    <= '0;
                        streak_q    <= '0;
                        drop_q      <= 1'b0;
                    end
                end
                StDBus: begin
                    if (done) begin
                        state_q   <= StIdle;
                        bus_req_q <= 1'b0;
                        if (tmo_hit) bus_timeout_q <= 1'b1;
                        if (bus_we_q) begin
                            st_done_q <= 1'b1;
                        end else begin
                            d_rdata_q  <= rdata;
                            dready_n_q <= 1'b0;
                        end
                    end else begin
                        tcount_q <= tcount_q + 1'b1;
                    end
                end
                StIBus: begin
                    if (done) begin
                        state_q   <= StIdle;
                        bus_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                        if (tmo_hit) bus_timeout_q <= 1'b1;
                        if (!(drop_q | i_flush_i)) begin
                            i_rdata_q  <= rdata;
                            iready_n_q <= 1'b0;
                        end
                    end else begin
                        tcount_q <= tcount_q + 1'b1;
                        if (i_flush_i) drop_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign i_rdata_o     = i_rdata_q;
    assign iready_n_o    = iready_n_q;
    assign d_rdata_o     = d_rdata_q;
    assign dready_n_o    = dready_n_q;
    assign dbusy_o       = d_req_i & d_we_i & ~st_done_q;
    assign bus_timeout_o = bus_timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests queue their expected grants
// and read data; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_flush, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic [31:0] i_rdata, d_rdata;
    logic        iready_n, dready_n, dbusy, bus_timeout;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .D_STREAK_MAX (4),
        .TIMEOUT      (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_i       (i_req),
        .i_addr_i      (i_addr),
        .i_flush_i     (i_flush),
        .i_rdata_o     (i_rdata),
        .iready_n_o    (iready_n),
        .d_req_i       (d_req),
        .d_we_i        (d_we),
        .d_be_i        (d_be),
        .d_addr_i      (d_addr),
        .d_wdata_i     (d_wdata),
        .d_rdata_o     (d_rdata),
        .dready_n_o    (dready_n),
        .dbusy_o       (dbusy),
        .bus           (bus),
        .bus_timeout_o (bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } grant_t;

    grant_t      exp_grant_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_i_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_delay = 0;
    logic [31:0] mem_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    // Memory model: ack after ack_delay waiting cycles; negative delay never acks.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !bus.bus_req || bus.bus_ack) begin
                bus.bus_ack = 1'b0;
                wcnt = 0;
            end else if (ack_delay >= 0 && wcnt == ack_delay) begin
                bus.bus_ack   = 1'b1;
                bus.bus_rdata = mem_rdata;
            end else begin
                wcnt++;
            end
        end
    end

    // Monitor: compares grants, bus stability and ready pulses against the queues.
    initial begin
        logic   prev_req;
        grant_t cur, g;
        prev_req = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus.bus_req && !prev_req) begin
                    if (exp_grant_q.size() == 0) begin
                        unexpected("grant");
                    end else begin
                        g = exp_grant_q.pop_front();
                        check("grant_addr", bus.bus_addr, g.addr);
                        check("grant_we", 32'(bus.bus_we), 32'(g.we));
                        check("grant_be", 32'(bus.bus_be), 32'(g.be));
                        if (g.we) check("grant_wdata", bus.bus_wdata, g.wdata);
                    end
                    cur = {bus.bus_addr, bus.bus_we, bus.bus_be, bus.bus_wdata};
                end else if (bus.bus_req) begin
                    check("bus_addr_stable", bus.bus_addr, cur.addr);
                    check("bus_ctrl_stable", {27'h0, bus.bus_we, bus.bus_be}, {27'h0, cur.we, cur.be});
                    check("bus_wdata_stable", bus.bus_wdata, cur.wdata);
                end
                prev_req = bus.bus_req;
                if (!dready_n) begin
                    if (exp_d_q.size() == 0) unexpected("dready_pulse");
                    else check("d_rdata", d_rdata, exp_d_q.pop_front());
                end
                if (!iready_n) begin
                    if (exp_i_q.size() == 0) unexpected("iready_pulse");
                    else check("i_rdata", i_rdata, exp_i_q.pop_front());
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic d_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] mem_val,
                            input logic [31:0] exp_val, input int delay, output int cyc);
        grant_t g;
        g.addr = addr;
        g.we = we;
        g.be = we ? be : 4'hF;
        g.wdata = wdata;
        exp_grant_q.push_back(g);
        if (!we) exp_d_q.push_back(exp_val);
        mem_rdata = mem_val;
        ack_delay = delay;
        d_addr = addr;
        d_we = we;
        d_be = be;
        d_wdata = wdata;
        d_req = 1'b1;
        cyc = 0;
        #1;
        while ((we ? dbusy : dready_n) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 100) unexpected("d_completion_timeout");
        d_req = 1'b0;
    endtask

    task automatic i_fetch(input logic [31:0] addr, input logic [31:0] val, input int delay,
                           output int cyc);
        grant_t g;
        g.addr = addr;
        g.we = 1'b0;
        g.be = 4'hF;
        g.wdata = 32'h0;
        exp_grant_q.push_back(g);
        exp_i_q.push_back(val);
        mem_rdata = val;
        ack_delay = delay;
        i_addr = addr;
        i_req = 1'b1;
        cyc = 0;
        #1;
        while (iready_n && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 100) unexpected("i_completion_timeout");
        i_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int     cyc, n;
        grant_t g;
        i_req = 0; i_flush = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        wait_cyc(3);

        // Reset state
        check("rst_bus_req", 32'(bus.bus_req), 0);
        check("rst_bus_be", 32'(bus.bus_be), 0);
        check("rst_bus_addr", bus.bus_addr, 0);
        check("rst_iready_n", 32'(iready_n), 1);
        check("rst_dready_n", 32'(dready_n), 1);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_bus_timeout", 32'(bus_timeout), 0);
        check("rst_dbusy", 32'(dbusy), 0);
        rst = 1'b0;
        wait_cyc(2);

        // 1: load, ack one cycle after bus_req; load forces bus_be to F
        d_access(32'h0000_1000, 1'b0, 4'h5, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, cyc);
        check("t1_latency", cyc, 3);
        wait_cyc(1);
        check("t1_pulse_width", 32'(dready_n), 1);
        wait_cyc(2);

        // 2: store, ack after 3 waiting cycles; dbusy covers request through ack cycle
        d_access(32'h0000_0100, 1'b1, 4'h3, 32'h1234_5678, 32'h0, 32'h0, 3, cyc);
        check("t2_dbusy_cycles", cyc, 5);
        check("t2_d_rdata_kept", d_rdata, 32'hDEAD_BEEF);
        wait_cyc(2);

        // plain fetch with immediate ack
        i_fetch(32'h0000_2000, 32'hCAFE_F00D, 0, cyc);
        check("fetch_latency", cyc, 2);
        wait_cyc(2);

        // 3: streak limit; flush holds off fetch until D has used its 4 grants
        mem_rdata = 32'h3333_0000;
        ack_delay = 0;
        g = '{addr: 32'h200, we: 1'b0, be: 4'hF, wdata: 32'h0};
        for (int k = 0; k < 4; k++) begin
            exp_grant_q.push_back(g);
            exp_d_q.push_back(32'h3333_0000);
        end
        exp_grant_q.push_back('{addr: 32'h300, we: 1'b0, be: 4'hF, wdata: 32'h0});
        exp_i_q.push_back(32'h3333_0000);
        exp_grant_q.push_back(g);
        exp_d_q.push_back(32'h3333_0000);
        i_addr = 32'h300; i_flush = 1; i_req = 1;
        d_addr = 32'h200; d_we = 0; d_be = 4'hF; d_req = 1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            if (!dready_n) n++;
        end
        check("t3_d_grants", n, 4);
        wait_cyc(3);
        check("t3_streak_stall", 32'(bus.bus_req), 0);
        i_flush = 0;
        cyc = 0;
        while (iready_n && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("t3_i_served", 32'(iready_n), 0);
        i_req = 0;
        cyc = 0;
        while (dready_n && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("t3_d_resumed", 32'(dready_n), 0);
        d_req = 0;
        wait_cyc(2);

        // 4: flush mid-fetch discards the result; the next fetch returns normally
        mem_rdata = 32'h4444_4444;
        ack_delay = 4;
        exp_grant_q.push_back('{addr: 32'h40, we: 1'b0, be: 4'hF, wdata: 32'h0});
        i_addr = 32'h40; i_req = 1;
        wait_cyc(2);
        i_flush = 1; i_req = 0;
        wait_cyc(1);
        i_flush = 0;
        cyc = 0;
        while (bus.bus_req && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check("t4_bus_released", 32'(bus.bus_req), 0);
        check("t4_no_iready", 32'(iready_n), 1);
        wait_cyc(2);
        i_fetch(32'h0000_0080, 32'h8080_0808, 2, cyc);
        check("t4_next_fetch_latency", cyc, 4);
        wait_cyc(2);

        // 5: watchdog aborts a load that is never acked
        d_access(32'h0000_0500, 1'b0, 4'hF, 32'h0, 32'hFFFF_FFFF, 32'h0, -1, cyc);
        check("t5_abort_latency", cyc, TMO + 1);
        check("t5_bus_req_low", 32'(bus.bus_req), 0);
        check("t5_bus_timeout", 32'(bus_timeout), 1);
        wait_cyc(2);
        d_access(32'h0000_0504, 1'b0, 4'hF, 32'h0, 32'h5555_AAAA, 32'h5555_AAAA, 0, cyc);
        check("t5_sticky", 32'(bus_timeout), 1);
        wait_cyc(2);

        // 6: asynchronous reset mid-transaction
        ack_delay = -1;
        exp_grant_q.push_back('{addr: 32'h600, we: 1'b0, be: 4'hF, wdata: 32'h0});
        d_addr = 32'h600; d_we = 0; d_be = 4'hF; d_req = 1;
        wait_cyc(2);
        check("t6_req_before_rst", 32'(bus.bus_req), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_req_async_drop", 32'(bus.bus_req), 0);
        check("t6_bus_addr", bus.bus_addr, 0);
        check("t6_bus_timeout", 32'(bus_timeout), 0);
        check("t6_d_rdata", d_rdata, 0);
        check("t6_dready_n", 32'(dready_n), 1);
        d_req = 0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(1);
        d_access(32'h0000_0640, 1'b0, 4'hF, 32'h0, 32'h6464_6464, 32'h6464_6464, 0, cyc);
        check("t6_after_release", cyc, 2);
        wait_cyc(3);

        check("sb_drained", exp_grant_q.size() + exp_d_q.size() + exp_i_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
